// File: rtl/ffe_pam4_slicer.sv
// PAM4 slicer behind the FFE: slices each strobed sample, computes the slicer
// error against the ideal level and queues {symbol, error} in a show-ahead FIFO.
module ffe_pam4_slicer #(
  parameter int DATA_WIDTH = 12,
  parameter int THRESH     = 512,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     sample_in,
  input  logic                      sample_vld,
  input  logic                      clr_ovf,
  output logic [1:0]                out_symbol,
  output logic [DATA_WIDTH:0]       out_error,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow,
  output logic [7:0]                drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + 1;

  localparam logic signed [EW-1:0] T_POS = EW'(THRESH);
  localparam logic signed [EW-1:0] T_NEG = EW'(-THRESH);
  localparam logic signed [EW-1:0] L_P3  = EW'(3 * THRESH / 2);
  localparam logic signed [EW-1:0] L_P1  = EW'(THRESH / 2);
  localparam logic signed [EW-1:0] L_N1  = EW'(-(THRESH / 2));
  localparam logic signed [EW-1:0] L_N3  = EW'(-(3 * THRESH / 2));

  typedef struct packed {
    logic [1:0]           sym;
    logic signed [EW-1:0] err;
  } entry_t;

  // ---------------- stage 1: slice ----------------
  logic signed [EW-1:0] samp_x, lvl;
  logic [1:0]           sym;
  entry_t               slice_d, stage_q;
  logic                 stage_vld;

  assign samp_x = {sample_in[DATA_WIDTH-1], sample_in};

  always_comb begin
    sym = 2'b00;
    lvl = L_N3;
    if (samp_x >= T_POS) begin
      sym = 2'b11;
      lvl = L_P3;
    end else if (!samp_x[EW-1]) begin
      sym = 2'b10;
      lvl = L_P1;
    end else if (samp_x >= T_NEG) begin
      sym = 2'b01;
      lvl = L_N1;
    end
  end

  // Sample is within +/-2^(DATA_WIDTH-1) and levels within +/-1.5*THRESH,
  // so the difference always fits in EW bits.
  assign slice_d = '{sym: sym, err: samp_x - lvl};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_vld <= 1'b0;
      stage_q   <= '0;
    end else begin
      stage_vld <= sample_vld;
      if (sample_vld) stage_q <= slice_d;
    end
  end

  // ---------------- stage 2: FIFO ----------------
  entry_t          mem [DEPTH];
  entry_t          last_q, head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, push, pop, drop;

  assign out_valid = (fifo_level != '0);
  assign full      = (fifo_level == (AW+1)'(DEPTH));
  assign pop       = out_valid & out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push      = stage_vld & (~full | pop);
  assign drop      = stage_vld & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stage_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      last_q     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Head when non-empty, otherwise the last popped entry is held.
  assign head       = out_valid ? mem[rd_ptr] : last_q;
  assign out_symbol = head.sym;
  assign out_error  = head.err;

  // ---------------- overflow tracking ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
